instr_decode_stage: RTL

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/instr_decode_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_decode_stage.sv
// Single-entry MIPS-style decode stage with a valid/ready hold register and an
// optional register busy scoreboard (enabled by defining SCOREBOARD_EN).
module instr_decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instrValid,
  output logic        instrReady,
  input  logic        exReady,
  input  logic        flush,
  input  logic        wbValid,
  input  logic [4:0]  wbDest,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rdest,
  output logic        regWriteEn,
  output logic        RaWriteEn,
  output logic [31:0] imm,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  shamt,
  output logic        outValid
);

  // Handshake: an instruction transfers on a rising edge where instrValid and
  // instrReady are both 1; the held decode leaves on an edge where outValid
  // and exReady are both 1 and flush is 0.

  logic [5:0]  dOp;
  logic [5:0]  dFunct;
  logic [4:0]  dRs;
  logic [4:0]  dRt;
  logic [4:0]  dRdest;
  logic        dWe;
  logic        dRa;
  logic [31:0] dImm;
  logic        hazard;
  logic        accept;

  assign dOp    = instr[31:26];
  assign dFunct = instr[5:0];
  assign dRs    = instr[25:21];
  assign dRt    = instr[20:16];

  always_comb begin
    dRdest = 5'd0;
    dWe    = 1'b0;
    dRa    = 1'b0;
    if (dOp == 6'h00) begin
      dRdest = instr[15:11];
      dWe    = (dFunct != 6'h08);
    end else if (dOp inside {[6'h08:6'h0F], [6'h20:6'h25]}) begin
      dRdest = instr[20:16];
      dWe    = 1'b1;
    end else if (dOp == 6'h03) begin
      dRdest = 5'd31;
      dRa    = 1'b1;
    end
    // Writes to $zero are architecturally discarded.
    if (dRdest == 5'd0) dWe = 1'b0;
  end

  always_comb begin
    dImm = {{16{instr[15]}}, instr[15:0]};
    if (dOp inside {[6'h0C:6'h0E]})       dImm = {16'h0000, instr[15:0]};
    else if (dOp == 6'h0F)                dImm = {instr[15:0], 16'h0000};
    else if (dOp inside {6'h02, 6'h03})   dImm = {6'b0, instr[25:0]};
  end

`ifdef SCOREBOARD_EN
  logic [31:0] busy;
  logic [31:0] busyNext;
  logic        heldWrites;
  logic        leave;
  logic        rsHit;
  logic        rtHit;

  assign heldWrites = outValid && (regWriteEn || RaWriteEn);
  assign leave      = outValid && exReady && !flush && (regWriteEn || RaWriteEn);

  // The held instruction is not yet in busy, so it is compared directly.
  assign rsHit  = (dRs != 5'd0) && (busy[dRs] || (heldWrites && (dRs == Rdest)));
  assign rtHit  = (dRt != 5'd0) && (busy[dRt] || (heldWrites && (dRt == Rdest)));
  assign hazard = instrValid && (rsHit || rtHit);

  always_comb begin
    busyNext = busy;
    if (wbValid) busyNext[wbDest] = 1'b0;
    if (leave)   busyNext[Rdest]  = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busyNext;
  end
`else
  logic unusedWb;
  assign unusedWb = ^{wbValid, wbDest};
  assign hazard   = 1'b0;
`endif

  assign instrReady = (!outValid || exReady) && !hazard && !flush && !reset;
  assign accept     = instrValid && instrReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid   <= 1'b0;
      regWriteEn <= 1'b0;
      RaWriteEn  <= 1'b0;
      Rs         <= '0;
      Rt         <= '0;
      Rdest      <= '0;
      imm        <= '0;
      opcode     <= '0;
      funct      <= '0;
      shamt      <= '0;
    end else begin
      if (flush)        outValid <= 1'b0;
      else if (accept)  outValid <= 1'b1;
      else if (exReady) outValid <= 1'b0;
      if (accept) begin
        regWriteEn <= dWe;
        RaWriteEn  <= dRa;
        Rs         <= dRs;
        Rt         <= dRt;
        Rdest      <= dRdest;
        imm        <= dImm;
        opcode     <= dOp;
        funct      <= dFunct;
        shamt      <= instr[10:6];
      end
    end
  end

endmodule
